address_calc: RTL and testbench
===============================

ADDRESS_CALC -- requirements
Module: address_calc

Interface
REQ-001 SHALL have parameter ADDR_W, default 26: width of all address ports and counters.
REQ-002 SHALL have parameter WIDTH_W, default 13: width of image_width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port sram_mode, input, 1: 1 selects row-cache pointer, 0 selects output pointer.
REQ-006 SHALL have port sdram_mode, input, 1: 1 selects read pointer, 0 selects write pointer.
REQ-007 SHALL have port sram_update, input, 1: advance the selected SRAM pointer.
REQ-008 SHALL have port sdram_update, input, 1: advance the selected SDRAM pointer.
REQ-009 SHALL have port start_flag, input, 1: reload all pointers.
REQ-010 SHALL have port image_width, input, WIDTH_W: pixels per row.
REQ-011 SHALL have ports start_address_sdram, finish_address_sdram, rowCache_address_sram, output_address_sram, each input, ADDR_W: base values for the read, write, row-cache and output pointers.
REQ-012 SHALL have ports sdram_address and sram_address, each output, ADDR_W: selected pointers.

Function
REQ-013 SHALL hold four independent registered pointers: RD, WR, RC and OUT.
REQ-014 SHALL drive sdram_address combinationally as RD when sdram_mode=1, else WR; a mode change is visible in the same cycle.
REQ-015 SHALL drive sram_address combinationally as RC when sram_mode=1, else OUT.
REQ-016 SHALL, on sdram_update=1, increment RD when sdram_mode=1, else WR, by 1 modulo 2^ADDR_W; the unselected pointer holds.
REQ-017 SHALL, on sram_update=1 with sram_mode=1, increment RC; once RC has advanced image_width times since its last load, it SHALL reload rowCache_address_sram instead.
REQ-018 SHALL, on sram_update=1 with sram_mode=0, increment OUT; once OUT has advanced image_width-1 times since its last load, it SHALL reload output_address_sram instead.
REQ-019 SHALL keep RC stuck at base when image_width=0, and OUT stuck at base when image_width<=1.
REQ-020 SHALL reload all four pointers from their base inputs on the clock edge where start_flag=1; the reloaded value is visible the next cycle.
REQ-021 SHALL give start_flag priority over any simultaneous update.
REQ-022 SHALL sample base inputs only on reset or start_flag; changes at other times have no effect until the next load.
REQ-023 SHALL apply simultaneous sram_update and sdram_update independently in the same cycle.
REQ-024 SHALL sample image_width each cycle for the wrap compare; a change mid-row uses the new value against the current advance count.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, load RD, WR, RC and OUT from their base inputs and clear the wrap counts; rst has priority over start_flag and updates.
REQ-026 SHALL, while rst is held, present the base addresses on the outputs according to the current modes.
REQ-027 SHALL treat reset asserted mid-row exactly as reset at idle.

Configuration
REQ-028 SHALL, with ADDRESS_CALC_ROW_DONE_EN defined, add output row_done, 1 bit, registered: high for exactly one cycle after the edge on which RC wraps to base; 0 on reset.
REQ-029 SHALL, without ADDRESS_CALC_ROW_DONE_EN, omit the row_done port and its logic entirely.

Structure
REQ-030 SHALL take ADDR_W, WIDTH_W and typedef addr_t (logic [ADDR_W-1:0]) from package address_calc_pkg.
REQ-031 SHALL implement each pointer with one sub-module, addr_counter, instantiated four times, with inputs load, base, inc, wrap_en and wrap_count; wrap_en=0 for RD and WR.

Verification
Common setup: rowCache_address_sram=0, output_address_sram=42, start_address_sdram=300, finish_address_sdram=3000, image_width=30.
REQ-032 SHALL check reset: rst=1 for one edge, then toggle both modes -> sram_address reads 42 (mode 0) and 0 (mode 1); sdram_address reads 3000 (mode 0) and 300 (mode 1).
REQ-033 SHALL check read/row-cache: 30 iterations of sdram_update then sram_update, both modes 1 -> RD steps 301..330; RC steps 1..29 then returns to 0 on the 30th update; OUT stays 42 and WR stays 3000.
REQ-034 SHALL check output wrap: sram_mode=0, 29 sram_update pulses -> OUT steps 43..70, then returns to 42 on the 29th pulse.
REQ-035 SHALL check write: both modes 0, 30 alternating sram_update/sdram_update pulses -> WR steps 3001..3030; OUT wraps after 29 pulses and ends at 43.
REQ-036 SHALL check start_flag: after arbitrary advances, one start_flag pulse with sdram_update=1 in the same cycle -> all pointers read base (300, 3000, 0, 42); the update is ignored.

Source files
------------

// File: rtl/address_calc_pkg.sv
// Shared widths and address type for the address calculator.
package address_calc_pkg;

    localparam int ADDR_W  = 26;
    localparam int WIDTH_W = 13;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/address_calc_addr_counter.sv
// One address pointer: loads a base, increments, and optionally wraps back
// to the stored base after wrap_count advances.
module addr_counter
    import address_calc_pkg::*;
#(
    parameter int ADDR_W  = address_calc_pkg::ADDR_W,
    parameter int WIDTH_W = address_calc_pkg::WIDTH_W
) (
    input  logic               clk,
    input  logic               load,
    input  logic [ADDR_W-1:0]  base,
    input  logic               inc,
    input  logic               wrap_en,
    input  logic [WIDTH_W-1:0] wrap_count,
    output logic [ADDR_W-1:0]  addr,
    output logic               wrap
);

    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WIDTH_W-1:0] cnt_q;
    logic [WIDTH_W:0]   adv;

    // adv is the advance count this increment would produce; >= makes a
    // shrinking wrap_count mid-row wrap on the next advance.
    assign adv  = {1'b0, cnt_q} + (WIDTH_W+1)'(1);
    assign wrap = inc & ~load & wrap_en & (adv >= {1'b0, wrap_count});
    assign addr = addr_q;

    always_ff @(posedge clk) begin
        if (load) begin
            base_q <= base;
            addr_q <= base;
            cnt_q  <= '0;
        end else if (inc) begin
            if (wrap) begin
                addr_q <= base_q;
                cnt_q  <= '0;
            end else begin
                addr_q <= addr_q + ADDR_W'(1);
                if (wrap_en) begin
                    cnt_q <= adv[WIDTH_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/address_calc.sv
// SDRAM read/write and SRAM row-cache/output address pointers.
// Optional row_done pulse enabled by defining ADDRESS_CALC_ROW_DONE_EN.
module address_calc
    import address_calc_pkg::*;
#(
    parameter int ADDR_W  = address_calc_pkg::ADDR_W,
    parameter int WIDTH_W = address_calc_pkg::WIDTH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sram_mode,
    input  logic               sdram_mode,
    input  logic               sram_update,
    input  logic               sdram_update,
    input  logic               start_flag,
    input  logic [WIDTH_W-1:0] image_width,
    input  logic [ADDR_W-1:0]  start_address_sdram,
    input  logic [ADDR_W-1:0]  finish_address_sdram,
    input  logic [ADDR_W-1:0]  rowCache_address_sram,
    input  logic [ADDR_W-1:0]  output_address_sram,
`ifdef ADDRESS_CALC_ROW_DONE_EN
    output logic               row_done,
`endif
    output logic [ADDR_W-1:0]  sdram_address,
    output logic [ADDR_W-1:0]  sram_address
);

    logic               load;
    logic [WIDTH_W-1:0] out_wrap_count;
    logic [ADDR_W-1:0]  rd_addr, wr_addr, rc_addr, out_addr;
    logic               rc_wrap;
    logic               unused_rd_wrap, unused_wr_wrap, unused_out_wrap;

    assign load = rst | start_flag;

    // OUT wraps one advance earlier than RC; width 0 or 1 keeps it at base.
    assign out_wrap_count = (image_width == '0) ? '0 : image_width - WIDTH_W'(1);

    addr_counter #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) u_rd (
        .clk        (clk),
        .load       (load),
        .base       (start_address_sdram),
        .inc        (sdram_update & sdram_mode),
        .wrap_en    (1'b0),
        .wrap_count ('0),
        .addr       (rd_addr),
        .wrap       (unused_rd_wrap)
    );

    addr_counter #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) u_wr (
        .clk        (clk),
        .load       (load),
        .base       (finish_address_sdram),
        .inc        (sdram_update & ~sdram_mode),
        .wrap_en    (1'b0),
        .wrap_count ('0),
        .addr       (wr_addr),
        .wrap       (unused_wr_wrap)
    );

    addr_counter #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) u_rc (
        .clk        (clk),
        .load       (load),
        .base       (rowCache_address_sram),
        .inc        (sram_update & sram_mode),
        .wrap_en    (1'b1),
        .wrap_count (image_width),
        .addr       (rc_addr),
        .wrap       (rc_wrap)
    );

    addr_counter #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) u_out (
        .clk        (clk),
        .load       (load),
        .base       (output_address_sram),
        .inc        (sram_update & ~sram_mode),
        .wrap_en    (1'b1),
        .wrap_count (out_wrap_count),
        .addr       (out_addr),
        .wrap       (unused_out_wrap)
    );

    assign sdram_address = sdram_mode ? rd_addr : wr_addr;
    assign sram_address  = sram_mode  ? rc_addr : out_addr;

`ifdef ADDRESS_CALC_ROW_DONE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            row_done <= 1'b0;
        end else begin
            row_done <= rc_wrap;
        end
    end
`else
    logic unused_rc_wrap;
    assign unused_rc_wrap = rc_wrap;
`endif

endmodule

// File: tb/tb_address_calc.sv
// Directed bench for address_calc: vector table plus hand-written corner sequences.
module tb_address_calc;
    import address_calc_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sram_mode = 1'b0, sdram_mode = 1'b0;
    logic         sram_update = 1'b0, sdram_update = 1'b0, start_flag = 1'b0;
    logic [12:0]  image_width = 13'd30;
    addr_t        start_address_sdram = 26'd300;
    addr_t        finish_address_sdram = 26'd3000;
    addr_t        rowCache_address_sram = 26'd0;
    addr_t        output_address_sram = 26'd42;
    addr_t        sdram_address, sram_address;
`ifdef ADDRESS_CALC_ROW_DONE_EN
    logic         row_done;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    address_calc dut (
        .clk                   (clk),
        .rst                   (rst),
        .sram_mode             (sram_mode),
        .sdram_mode            (sdram_mode),
        .sram_update           (sram_update),
        .sdram_update          (sdram_update),
        .start_flag            (start_flag),
        .image_width           (image_width),
        .start_address_sdram   (start_address_sdram),
        .finish_address_sdram  (finish_address_sdram),
        .rowCache_address_sram (rowCache_address_sram),
        .output_address_sram   (output_address_sram),
`ifdef ADDRESS_CALC_ROW_DONE_EN
        .row_done              (row_done),
`endif
        .sdram_address         (sdram_address),
        .sram_address          (sram_address)
    );

    typedef struct {
        string name;
        logic  sm, dm, su, du, sf;
        addr_t exp_sram, exp_sdram;
        logic  exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input addr_t act, input addr_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's controls, let the edge occur, then drop the pulses.
    task automatic step(input logic sm, input logic dm, input logic su,
                        input logic du, input logic sf);
        @(negedge clk);
        sram_mode = sm; sdram_mode = dm;
        sram_update = su; sdram_update = du; start_flag = sf;
        @(posedge clk);
        #1;
        sram_update = 1'b0; sdram_update = 1'b0; start_flag = 1'b0;
    endtask

    task automatic peek(input logic sm, input logic dm);
        sram_mode = sm; sdram_mode = dm;
        #1;
    endtask

    task automatic push(input string n, input logic sm, input logic dm, input logic su,
                        input logic du, input int es, input int ed, input logic done);
        vec_t v;
        v.name = n; v.sm = sm; v.dm = dm; v.su = su; v.du = du; v.sf = 1'b0;
        v.exp_sram = addr_t'(es); v.exp_sdram = addr_t'(ed); v.exp_done = done;
        vecs.push_back(v);
    endtask

    initial begin
        // Read / row-cache: RD 301..330, RC 1..29 then back to 0.
        for (int i = 1; i <= 30; i++) begin
            push("rd_step", 1, 1, 0, 1, i - 1, 300 + i, 0);
            push("rc_step", 1, 1, 1, 0, i % 30, 300 + i, i == 30);
        end
        push("out_wr_hold", 0, 0, 0, 0, 42, 3000, 0);
        // Output wrap after 29 pulses.
        for (int i = 1; i <= 29; i++)
            push("out_step", 0, 1, 1, 0, (i == 29) ? 42 : 42 + i, 330, 0);
        // Write pointer with alternating output pulses.
        for (int i = 1; i <= 30; i++) begin
            push("out_alt", 0, 0, 1, 0, (i < 29) ? 42 + i : ((i == 29) ? 42 : 43), 3000 + i - 1, 0);
            push("wr_step", 0, 0, 0, 1, (i < 29) ? 42 + i : ((i == 29) ? 42 : 43), 3000 + i, 0);
        end
        push("rc_rd_hold", 1, 1, 0, 0, 0, 330, 0);

        // Reset and mode toggling.
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        peek(0, 0);
        check("rst_out", sram_address, 26'd42);
        check("rst_wr", sdram_address, 26'd3000);
        peek(1, 1);
        check("rst_rc", sram_address, 26'd0);
        check("rst_rd", sdram_address, 26'd300);

        foreach (vecs[k]) begin
            step(vecs[k].sm, vecs[k].dm, vecs[k].su, vecs[k].du, vecs[k].sf);
            check({vecs[k].name, "_sram"}, sram_address, vecs[k].exp_sram);
            check({vecs[k].name, "_sdram"}, sdram_address, vecs[k].exp_sdram);
`ifdef ADDRESS_CALC_ROW_DONE_EN
            check({vecs[k].name, "_row_done"}, addr_t'(row_done), addr_t'(vecs[k].exp_done));
`endif
        end

        // Base inputs ignored until a load.
        start_address_sdram = 26'd500;
        step(1, 1, 0, 1, 0);
        check("base_not_sampled", sdram_address, 26'd331);
        start_address_sdram = 26'd300;

        // Simultaneous updates in one cycle.
        step(1, 1, 1, 1, 0);
        check("simul_rc", sram_address, 26'd1);
        check("simul_rd", sdram_address, 26'd332);

        // start_flag beats a same-cycle update.
        step(1, 1, 1, 1, 1);
        check("start_rc", sram_address, 26'd0);
        check("start_rd", sdram_address, 26'd300);
        peek(0, 0);
        check("start_out", sram_address, 26'd42);
        check("start_wr", sdram_address, 26'd3000);

        // Reset mid-row.
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        check("midrow_rc", sram_address, 26'd2);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rc", sram_address, 26'd0);
        check("midrst_rd", sdram_address, 26'd300);
        @(negedge clk); rst = 1'b0;
`ifdef ADDRESS_CALC_ROW_DONE_EN
        check("midrst_row_done", addr_t'(row_done), 26'd0);
`endif

        // Degenerate widths keep pointers at base.
        image_width = 13'd0;
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check("w0_rc_stuck", sram_address, 26'd0);
        image_width = 13'd1;
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check("w1_out_stuck", sram_address, 26'd42);
        step(1, 1, 1, 0, 0);
        check("w1_rc_wraps", sram_address, 26'd0);

        // Width shrink mid-row wraps on the next advance.
        image_width = 13'd30;
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check("shrink_pre", sram_address, 26'd3);
        image_width = 13'd2;
        step(1, 1, 1, 0, 0);
        check("shrink_wrap", sram_address, 26'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
